// File: rtl/seq_detector_pkg.sv
// Shared definitions for the serial pattern detector.
// Holds the FSM state encoding and the default LEN / PATTERN / CNT_W values
// so the detector, its interface and the upstream flip-flop bench stay in step.
package seq_detector_pkg;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam int             DEF_LEN     = 4;
  localparam logic [3:0]     DEF_PATTERN = 4'b1011;
  localparam int             DEF_CNT_W   = 8;

endpackage

// File: rtl/seq_detector_if.sv
// Bus bundle between the upstream bit source and seq_detector.
// Signals:
//   en     sample strobe (din consumed only when high)
//   din    serial data bit
//   clr    synchronous clear of the hit counter
//   match  one-cycle pulse when the window equals the pattern
//   hits   saturating match count since reset/clr
//   window last LEN sampled bits, bit 0 newest
//   ready  high once LEN bits have been sampled since reset
// Modports: master drives the stream, slave is the detector.
interface seq_detector_if
  import seq_detector_pkg::*;
#(
  parameter int LEN   = DEF_LEN,
  parameter int CNT_W = DEF_CNT_W
) ();

  logic             en;
  logic             din;
  logic             clr;
  logic             match;
  logic [CNT_W-1:0] hits;
  logic [LEN-1:0]   window;
  logic             ready;

  modport master (
    output en, din, clr,
    input  match, hits, window, ready
  );

  modport slave (
    input  en, din, clr,
    output match, hits, window, ready
  );

endinterface

// File: rtl/seq_detector_sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk  system clock
//   rst  synchronous active-high reset (highest priority)
//   clr  clear; combined with inc the result is 1 (clear, then count)
//   inc  count enable
//   cnt  current count, sticks at all-ones
module sat_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= inc ? W'(1) : '0;
    end else if (inc && (cnt_reg != '1)) begin
      cnt_reg <= cnt_reg + W'(1);
    end
  end

  assign cnt = cnt_reg;

endmodule

// File: rtl/seq_detector.sv
// Serial pattern detector fed by the JK flip-flop stage's q output.
// Shifts din into a LEN-bit window on every en=1 edge and pulses match for
// one clock whenever the window equals PATTERN, overlaps included. A FILL
// state suppresses matches until LEN samples have been taken since reset.
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset, overrides everything
//   bus  seq_detector_if.slave: en, din, clr in; match, hits, window, ready out
module seq_detector
  import seq_detector_pkg::*;
#(
  parameter int             LEN     = DEF_LEN,
  parameter logic [LEN-1:0] PATTERN = LEN'(DEF_PATTERN),
  parameter int             CNT_W   = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst,
  seq_detector_if.slave      bus
);

  localparam int FILL_W = $clog2(LEN + 1);

  state_t           state_reg, state_next;
  logic [LEN-1:0]   window_reg, window_next;
  logic             match_reg, match_next;
  logic [FILL_W-1:0] fill_cnt;
  logic [CNT_W-1:0] hits_cnt;
  logic             fill_inc;
  logic             last_fill;

  // Counts accepted samples during FILL only; it stops moving once in RUN.
  assign fill_inc  = bus.en && (state_reg == ST_FILL);
  assign last_fill = fill_inc && (fill_cnt == FILL_W'(LEN - 1));

  sat_counter #(.W(FILL_W)) u_fill_cnt (
    .clk (clk),
    .rst (rst),
    .clr (1'b0),
    .inc (fill_inc),
    .cnt (fill_cnt)
  );

  always_comb begin
    state_next  = state_reg;
    window_next = window_reg;
    match_next  = 1'b0;
    if (bus.en) begin
      window_next = {window_reg[LEN-2:0], bus.din};
      // The zero-initialised window may equal PATTERN during FILL, so the
      // compare is only honoured in RUN or on the completing LEN-th sample.
      if (state_reg == ST_RUN) begin
        match_next = (window_next == PATTERN);
      end else if (last_fill) begin
        match_next = (window_next == PATTERN);
        state_next = ST_RUN;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ST_FILL;
      window_reg <= '0;
      match_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      window_reg <= window_next;
      match_reg  <= match_next;
    end
  end

  // Counts on the same edge that raises match, so hits and match agree.
  sat_counter #(.W(CNT_W)) u_hits (
    .clk (clk),
    .rst (rst),
    .clr (bus.clr),
    .inc (match_next),
    .cnt (hits_cnt)
  );

  assign bus.match  = match_reg;
  assign bus.hits   = hits_cnt;
  assign bus.window = window_reg;
  assign bus.ready  = (state_reg == ST_RUN);

endmodule

// File: tb/tb_seq_detector.sv
// Self-checking bench for seq_detector. Three instances share one stimulus
// stream: default (1011, 8-bit hits), PATTERN=0000, and 1011 with 2-bit hits.
// A reference model keeps the recent sampled bits in a queue plus a sample
// count and derives window/match/ready/hits from those.
module tb_seq_detector;
  import seq_detector_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_detector_if #(.LEN(4), .CNT_W(8)) bus_a ();
  seq_detector_if #(.LEN(4), .CNT_W(8)) bus_b ();
  seq_detector_if #(.LEN(4), .CNT_W(2)) bus_c ();

  seq_detector #(.LEN(4), .PATTERN(4'b1011), .CNT_W(8)) u_a (
    .clk (clk), .rst (rst), .bus (bus_a));
  seq_detector #(.LEN(4), .PATTERN(4'b0000), .CNT_W(8)) u_b (
    .clk (clk), .rst (rst), .bus (bus_b));
  seq_detector #(.LEN(4), .PATTERN(4'b1011), .CNT_W(2)) u_c (
    .clk (clk), .rst (rst), .bus (bus_c));

  int total = 0;
  int bad   = 0;
  int txn   = 0;

  // reference model state
  bit         hist[$];
  int         nsamp;
  logic [3:0] exp_win;
  int         exp_hits  [3];
  bit         exp_match [3];
  int         hit_max   [3] = '{255, 255, 3};
  logic [3:0] pat       [3] = '{4'b1011, 4'b0000, 4'b1011};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s txn=%0d: got=%0h expected=%0h", tag, txn, got, exp);
    end
  endtask

  task automatic model_update(input bit r, input bit e, input bit d, input bit c);
    if (r) begin
      hist.delete();
      nsamp = 0;
      for (int k = 0; k < 3; k++) begin
        exp_hits[k]  = 0;
        exp_match[k] = 1'b0;
      end
    end else begin
      if (e) begin
        hist.push_back(d);
        if (hist.size() > 4) void'(hist.pop_front());
        if (nsamp < 4) nsamp++;
      end
      for (int k = 0; k < 3; k++) begin
        if (c) exp_hits[k] = 0;
      end
    end
    exp_win = 4'b0000;
    for (int i = 0; i < hist.size(); i++) exp_win[i] = hist[hist.size() - 1 - i];
    if (!r) begin
      for (int k = 0; k < 3; k++) begin
        exp_match[k] = e && (nsamp >= 4) && (exp_win == pat[k]);
        if (exp_match[k] && exp_hits[k] < hit_max[k]) exp_hits[k]++;
      end
    end
  endtask

  task automatic check_all();
    check("a.match",  32'(bus_a.match),  32'(exp_match[0]));
    check("a.hits",   32'(bus_a.hits),   32'(exp_hits[0]));
    check("a.window", 32'(bus_a.window), 32'(exp_win));
    check("a.ready",  32'(bus_a.ready),  32'(nsamp >= 4));
    check("b.match",  32'(bus_b.match),  32'(exp_match[1]));
    check("b.hits",   32'(bus_b.hits),   32'(exp_hits[1]));
    check("b.window", 32'(bus_b.window), 32'(exp_win));
    check("b.ready",  32'(bus_b.ready),  32'(nsamp >= 4));
    check("c.match",  32'(bus_c.match),  32'(exp_match[2]));
    check("c.hits",   32'(bus_c.hits),   32'(exp_hits[2]));
    check("c.window", 32'(bus_c.window), 32'(exp_win));
    check("c.ready",  32'(bus_c.ready),  32'(nsamp >= 4));
  endtask

  // One transaction: drive inputs, clock once, update model, compare.
  task automatic step(input bit r, input bit e, input bit d, input bit c);
    rst = r;
    bus_a.en = e; bus_a.din = d; bus_a.clr = c;
    bus_b.en = e; bus_b.din = d; bus_b.clr = c;
    bus_c.en = e; bus_c.din = d; bus_c.clr = c;
    @(posedge clk);
    model_update(r, e, d, c);
    #1;
    txn++;
    check_all();
    $display("txn %0d rst=%0b en=%0b din=%0b clr=%0b | win=%b match=%0b/%0b/%0b hits=%0d/%0d/%0d ready=%0b",
             txn, r, e, d, c, bus_a.window, bus_a.match, bus_b.match, bus_c.match,
             bus_a.hits, bus_b.hits, bus_c.hits, bus_a.ready);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  bit seq7 [7] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
  bit pat4 [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst = 1'b1;
    bus_a.en = 1'b0; bus_a.din = 1'b0; bus_a.clr = 1'b0;
    bus_b.en = 1'b0; bus_b.din = 1'b0; bus_b.clr = 1'b0;
    bus_c.en = 1'b0; bus_c.din = 1'b0; bus_c.clr = 1'b0;

    // reset state
    do_reset();
    do_reset();

    // 1011011 back to back: pulses on samples 4 and 7
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, seq7[i], 1'b0);
    // 0,1 then completing 1 with clr on the same edge: hits becomes 1
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // same stream with a 3-cycle idle gap between samples 2 and 3
    do_reset();
    for (int i = 0; i < 2; i++) step(1'b0, 1'b1, seq7[i], 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    for (int i = 2; i < 7; i++) step(1'b0, 1'b1, seq7[i], 1'b0);

    // continuous zeros: PATTERN=0 instance matches from sample 4, saturates at 255
    do_reset();
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 1'b0, 1'b0);

    // six non-overlapping 1011 occurrences: 2-bit counter saturates at 3
    do_reset();
    for (int n = 0; n < 6; n++)
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pat4[i], 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // reset mid-stream discards partial history
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, pat4[i], 1'b0);
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, pat4[i], 1'b0);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      step(($urandom_range(0, 199) == 0),
           ($urandom_range(0, 9) < 7),
           1'($urandom_range(0, 1)),
           ($urandom_range(0, 59) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
